// File: rtl/det_m_feeder.sv
// Stream-to-matrix front end for the 3x3 determinant core: gathers nine beats,
// fires the core, waits for done under a timeout and returns the result.
module det_m_feeder #(
    parameter int TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [31:0]  in_data,
    input  logic         in_valid,
    input  logic         in_last,
    output logic         in_ready,
    output logic [287:0] m_flat,
    output logic         core_start,
    input  logic         core_busy,
    input  logic         core_done,
    input  logic [31:0]  core_det,
    output logic [31:0]  res_data,
    output logic         res_err,
    output logic         res_valid,
    input  logic         res_ready,
    output logic         frame_err
);

    typedef enum logic [1:0] {
        S_FILL = 2'd0,
        S_FIRE = 2'd1,
        S_WAIT = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT);

    state_t         state_q, state_d;
    logic [3:0]     idx_q, idx_d;
    logic [15:0]    cnt_q, cnt_d;
    logic [287:0]   m_q, m_d;
    logic [31:0]    res_data_q, res_data_d;
    logic           res_err_q, res_err_d;
    logic           res_valid_q, res_valid_d;
    logic           in_ready_q, in_ready_d;
    logic           core_start_q, core_start_d;
    logic           frame_err_q, frame_err_d;
    logic           accept_s;
    logic           busy_unused_s;

    // core_busy is a debug-only observation point
    assign busy_unused_s = core_busy;
    assign accept_s      = in_valid & in_ready_q;

    // Next-state and registered-output computation
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        m_d          = m_q;
        res_data_d   = res_data_q;
        res_err_d    = res_err_q;
        res_valid_d  = res_valid_q;
        core_start_d = 1'b0;
        frame_err_d  = 1'b0;
        case (state_q)
            S_FILL: begin
                if (accept_s) begin
                    m_d[{idx_q, 5'd0} +: 32] = in_data;
                    if (idx_q == 4'd8) begin
                        idx_d = 4'd0;
                        if (in_last) begin
                            state_d      = S_FIRE;
                            core_start_d = 1'b1;
                        end else begin
                            frame_err_d = 1'b1;
                        end
                    end else if (in_last) begin
                        idx_d       = 4'd0;
                        frame_err_d = 1'b1;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end else begin
                    idx_d = idx_q;
                end
            end
            S_FIRE: begin
                state_d = S_WAIT;
                cnt_d   = 16'd0;
            end
            S_WAIT: begin
                cnt_d = cnt_q + 16'd1;
                // done wins over a coincident timeout
                if (core_done) begin
                    res_data_d  = core_det;
                    res_err_d   = 1'b0;
                    res_valid_d = 1'b1;
                    state_d     = S_OUT;
                end else if (cnt_q + 16'd1 == TO_LIMIT) begin
                    res_data_d  = 32'd0;
                    res_err_d   = 1'b1;
                    res_valid_d = 1'b1;
                    state_d     = S_OUT;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_OUT: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    idx_d       = 4'd0;
                    cnt_d       = 16'd0;
                    state_d     = S_FILL;
                end else begin
                    res_valid_d = 1'b1;
                end
            end
            default: begin
                state_d = S_FILL;
                idx_d   = 4'd0;
                cnt_d   = 16'd0;
            end
        endcase
        in_ready_d = (state_d == S_FILL);
    end

    // State and output registers with asynchronous clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_FILL;
            idx_q        <= 4'd0;
            cnt_q        <= 16'd0;
            m_q          <= 288'd0;
            res_data_q   <= 32'd0;
            res_err_q    <= 1'b0;
            res_valid_q  <= 1'b0;
            in_ready_q   <= 1'b0;
            core_start_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            m_q          <= m_d;
            res_data_q   <= res_data_d;
            res_err_q    <= res_err_d;
            res_valid_q  <= res_valid_d;
            in_ready_q   <= in_ready_d;
            core_start_q <= core_start_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign m_flat     = m_q;
    assign core_start = core_start_q;
    assign res_data   = res_data_q;
    assign res_err    = res_err_q;
    assign res_valid  = res_valid_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_det_m_feeder.sv
// Directed bench for det_m_feeder with a small behavioural determinant core.
module tb_det_m_feeder;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [31:0]  in_data = 32'd0;
    logic         in_valid = 1'b0;
    logic         in_last = 1'b0;
    logic         in_ready;
    logic [287:0] m_flat;
    logic         core_start;
    logic         core_busy;
    logic         core_done;
    logic [31:0]  core_det;
    logic [31:0]  res_data;
    logic         res_err;
    logic         res_valid;
    logic         res_ready = 1'b1;
    logic         frame_err;

    int errors = 0;
    int checks = 0;
    int cyc = 0, start_cyc = 0, rv_cyc = 0, start_cnt = 0, ferr_cnt = 0;
    logic        rv_prev = 1'b0;
    logic [2:0]  sr = 3'd0;
    logic [31:0] det_q = 32'd0;
    logic        model_en = 1'b1;
    logic        extra_done = 1'b0;

    localparam logic [287:0] IDENT = {32'd1, 32'd0, 32'd0, 32'd0, 32'd1, 32'd0, 32'd0, 32'd0, 32'd1};
    localparam logic [287:0] DIAG  = {32'd4, 32'd0, 32'd0, 32'd0, 32'd3, 32'd0, 32'd0, 32'd0, 32'd2};
    localparam logic [287:0] PERM  = {32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd1, 32'd0, 32'd1, 32'd0};

    det_m_feeder #(.TIMEOUT(16)) dut (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .m_flat(m_flat), .core_start(core_start), .core_busy(core_busy),
        .core_done(core_done), .core_det(core_det),
        .res_data(res_data), .res_err(res_err), .res_valid(res_valid), .res_ready(res_ready),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] det3(input logic [287:0] m);
        int a[9];
        int d;
        for (int i = 0; i < 9; i++) a[i] = $signed(m[32*i +: 32]);
        d = a[0] * (a[4] * a[8] - a[5] * a[7])
          - a[1] * (a[3] * a[8] - a[5] * a[6])
          + a[2] * (a[3] * a[7] - a[4] * a[6]);
        return 32'(d);
    endfunction

    // Core model: start sampled, then CALC, DONE, registered done one cycle later
    always @(posedge clk) begin
        cyc     <= cyc + 1;
        rv_prev <= res_valid;
        sr      <= {sr[1:0], core_start & model_en};
        if (core_start) begin
            start_cnt <= start_cnt + 1;
            start_cyc <= cyc;
            det_q     <= det3(m_flat);
        end
        if (res_valid && !rv_prev) rv_cyc <= cyc;
        if (frame_err) ferr_cnt <= ferr_cnt + 1;
    end

    assign core_done = sr[2] | extra_done;
    assign core_det  = core_done ? det_q : 32'd0;
    assign core_busy = |sr[1:0];

    task automatic send_frame(input logic [287:0] f, input int nbeats, input bit gap);
        for (int k = 0; k < nbeats; k++) begin
            int n;
            n = 0;
            in_data  = f[32*k +: 32];
            in_last  = (k == nbeats - 1);
            in_valid = 1'b1;
            while (in_ready !== 1'b1 && n < 100) begin
                @(negedge clk);
                n++;
            end
            checks++;
            if (n >= 100) begin
                errors++;
                $display("FAIL beat_accept: beat %0d not accepted, in_ready=%b required 1", k, in_ready);
            end
            @(negedge clk);
            if (gap && k < nbeats - 1) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_result();
        int n;
        n = 0;
        while (res_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL result_wait: res_valid=%b required 1 within 200 cycles", res_valid);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({in_ready, core_start, res_valid, res_err, frame_err} !== 5'd0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b required 00000", {in_ready, core_start, res_valid, res_err, frame_err});
        end
        checks++;
        if (m_flat !== 288'd0 || res_data !== 32'd0) begin
            errors++;
            $display("FAIL reset_data: res_data=%h m_flat nonzero=%b required 0", res_data, |m_flat);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b required 1", in_ready);
        end
    endtask

    task automatic test_identity();
        int sc0;
        sc0 = start_cnt;
        send_frame(IDENT, 9, 1'b0);
        checks++;
        if (core_start !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL fire_timing: core_start=%b in_ready=%b required 1 0", core_start, in_ready);
        end
        wait_result();
        checks++;
        if (res_data !== 32'h00000001 || res_err !== 1'b0) begin
            errors++;
            $display("FAIL identity_result: got %h err=%b required 00000001 err=0", res_data, res_err);
        end
        @(negedge clk);
        checks++;
        if (rv_cyc - start_cyc !== 4) begin
            errors++;
            $display("FAIL done_latency: got %0d required 4", rv_cyc - start_cyc);
        end
        checks++;
        if (res_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL back_to_back: res_valid=%b in_ready=%b required 0 1", res_valid, in_ready);
        end
        checks++;
        if (start_cnt - sc0 !== 1) begin
            errors++;
            $display("FAIL start_count: got %0d required 1", start_cnt - sc0);
        end
    endtask

    task automatic test_diagonal();
        send_frame(DIAG, 9, 1'b1);
        checks++;
        if (m_flat !== DIAG) begin
            errors++;
            $display("FAIL diag_mflat: got %h required %h", m_flat, DIAG);
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (m_flat !== DIAG) begin
            errors++;
            $display("FAIL diag_mflat_wait: got %h required %h", m_flat, DIAG);
        end
        wait_result();
        checks++;
        if (res_data !== 32'd24 || res_err !== 1'b0) begin
            errors++;
            $display("FAIL diag_result: got %0d err=%b required 24 err=0", res_data, res_err);
        end
        @(negedge clk);
    endtask

    task automatic test_permutation();
        bit bad;
        bad = 1'b0;
        res_ready = 1'b0;
        send_frame(PERM, 9, 1'b0);
        wait_result();
        for (int i = 0; i < 10; i++) begin
            if (res_valid !== 1'b1 || res_data !== 32'hFFFFFFFF || res_err !== 1'b0 || in_ready !== 1'b0) bad = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL perm_hold: res_valid=%b res_data=%h in_ready=%b required 1 ffffffff 0", res_valid, res_data, in_ready);
        end
        res_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL perm_accept: res_valid=%b in_ready=%b required 0 1", res_valid, in_ready);
        end
    endtask

    task automatic test_short_frame();
        int sc0, fe0;
        sc0 = start_cnt;
        fe0 = ferr_cnt;
        send_frame(IDENT, 5, 1'b0);
        checks++;
        if (frame_err !== 1'b1 || core_start !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL short_frame: frame_err=%b core_start=%b in_ready=%b required 1 0 1", frame_err, core_start, in_ready);
        end
        @(negedge clk);
        checks++;
        if (frame_err !== 1'b0 || start_cnt !== sc0 || ferr_cnt - fe0 !== 1) begin
            errors++;
            $display("FAIL short_pulse: frame_err=%b starts=%0d pulses=%0d required 0 0 1", frame_err, start_cnt - sc0, ferr_cnt - fe0);
        end
        send_frame(IDENT, 9, 1'b0);
        wait_result();
        checks++;
        if (res_data !== 32'd1 || res_err !== 1'b0) begin
            errors++;
            $display("FAIL after_short: got %h err=%b required 00000001 err=0", res_data, res_err);
        end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        model_en = 1'b0;
        send_frame(IDENT, 9, 1'b0);
        wait_result();
        checks++;
        if (res_err !== 1'b1 || res_data !== 32'd0) begin
            errors++;
            $display("FAIL timeout_result: got %h err=%b required 00000000 err=1", res_data, res_err);
        end
        @(negedge clk);
        checks++;
        if (rv_cyc - start_cyc !== 17) begin
            errors++;
            $display("FAIL timeout_latency: got %0d required 17", rv_cyc - start_cyc);
        end
        model_en = 1'b1;
        send_frame(DIAG, 9, 1'b0);
        wait_result();
        checks++;
        if (res_data !== 32'd24 || res_err !== 1'b0) begin
            errors++;
            $display("FAIL after_timeout: got %0d err=%b required 24 err=0", res_data, res_err);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int sc0;
        bit bad;
        bad = 1'b0;
        send_frame(IDENT, 9, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        sc0 = start_cnt;
        checks++;
        if ({in_ready, core_start, res_valid, res_err, frame_err} !== 5'd0 || m_flat !== 288'd0 || res_data !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid: ctrl=%b res_data=%h m_flat nonzero=%b required all 0",
                     {in_ready, core_start, res_valid, res_err, frame_err}, res_data, |m_flat);
        end
        @(negedge clk);
        reset      = 1'b0;
        extra_done = 1'b1;
        @(negedge clk);
        extra_done = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_release: in_ready=%b res_valid=%b required 1 0", in_ready, res_valid);
        end
        for (int i = 0; i < 6; i++) begin
            if (res_valid !== 1'b0 || core_start !== 1'b0) bad = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (bad || start_cnt !== sc0) begin
            errors++;
            $display("FAIL late_done: res_valid/core_start seen=%b starts=%0d required 0 0", bad, start_cnt - sc0);
        end
        send_frame(IDENT, 9, 1'b0);
        wait_result();
        checks++;
        if (res_data !== 32'd1 || res_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_recover: got %h err=%b required 00000001 err=0", res_data, res_err);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_identity();
        test_diagonal();
        test_permutation();
        test_short_frame();
        test_timeout();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
